// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word intake handshake plus serial bit stream of the PISO transmitter.
// The upstream/downstream side drives I, load and shift_en; the serializer drives the rest.
interface piso_serializer_if #(
    parameter int n = 4
);
    logic [n-1:0] I;
    logic         load;
    logic         ready;
    logic         shift_en;
    logic         SO;
    logic         so_valid;
    logic         so_last;
    logic         busy;

    modport master (
        output I, load, shift_en,
        input  ready, SO, so_valid, so_last, busy
    );

    modport slave (
        input  I, load, shift_en,
        output ready, SO, so_valid, so_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter. A word accepted on load && ready is
// shifted out one bit per enabled cycle, with so_valid/so_last markers. A new word can be
// taken on the same edge that consumes the last bit, so words stream without gaps.
module piso_serializer #(
    parameter int n         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    piso_serializer_if.slave bus
);
    localparam int            CW      = $clog2(n);
    localparam logic [CW-1:0] CNT_MAX = CW'(n - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;   // bits remaining after the one on SO
    logic          last_bit;
    logic          ready;

    // Moves the next bit into the output position and zero-fills the vacated end.
    function automatic logic [n-1:0] advance(input logic [n-1:0] v);
        if (LSB_FIRST) return {1'b0, v[n-1:1]};
        return {v[n-2:0], 1'b0};
    endfunction

    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
    // A word can be taken while idle, or on the edge that consumes the final bit.
    assign ready    = (state_q == IDLE) || (last_bit && bus.shift_en);

    // Next-state logic: capture on handshake, shift on enable, hand off or retire on last bit.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned
        // and no latch can be inferred.
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.load && ready) begin
                    sr_d    = bus.I;
                    cnt_d   = CNT_MAX;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_q != '0) begin
                        sr_d  = advance(sr_q);
                        cnt_d = cnt_q - CW'(1);
                    end else if (bus.load) begin
                        // Back-to-back hand-off: next word's first bit follows immediately.
                        sr_d  = bus.I;
                        cnt_d = CNT_MAX;
                    end else begin
                        sr_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any word in flight at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.SO       = LSB_FIRST ? sr_q[0] : sr_q[n-1];
    assign bus.so_valid = (state_q == SHIFT);
    assign bus.busy     = (state_q == SHIFT);
    assign bus.so_last  = last_bit;
    assign bus.ready    = ready;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an n=4 LSB-first and an n=8 MSB-first serializer. A bit-queue
// model predicts every output each cycle; directed scenarios pin the model with literal
// expectations, then a randomized phase streams words with random stalls and a reset.
module tb_piso_serializer;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    piso_serializer_if #(.n(4)) bus_a ();
    piso_serializer_if #(.n(8)) bus_b ();

    piso_serializer #(.n(4), .LSB_FIRST(1'b1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    piso_serializer #(.n(8), .LSB_FIRST(1'b0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: bits still to be sent, in transmit order, and words waiting upstream.
    bit         mq_a[$];
    bit         mq_b[$];
    logic [7:0] fq_a[$];
    logic [7:0] fq_b[$];
    bit         acc_a, cons_a, acc_b, cons_b;
    bit         exp_ready_a, exp_ready_b, exp_so_a, exp_so_b;

    logic [15:0] rec_so, rec_valid, rec_last, rec_ready, rec_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream presents the head of its queue and holds it until accepted.
    task automatic refresh();
        bus_a.load = (fq_a.size() != 0);
        bus_a.I    = (fq_a.size() != 0) ? fq_a[0][3:0] : 4'($urandom);
        bus_b.load = (fq_b.size() != 0);
        bus_b.I    = (fq_b.size() != 0) ? fq_b[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs cycles with a per-cycle shift_en pattern, recording outputs mid-cycle.
    task automatic run(input bit sel, input int cycles, input logic [15:0] en);
        rec_so = '0; rec_valid = '0; rec_last = '0; rec_ready = '0; rec_busy = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            if (sel) bus_b.shift_en = en[i];
            else     bus_a.shift_en = en[i];
            @(negedge clk);
            rec_so[i]    = sel ? bus_b.SO       : bus_a.SO;
            rec_valid[i] = sel ? bus_b.so_valid : bus_a.so_valid;
            rec_last[i]  = sel ? bus_b.so_last  : bus_a.so_last;
            rec_ready[i] = sel ? bus_b.ready    : bus_a.ready;
            rec_busy[i]  = sel ? bus_b.busy     : bus_a.busy;
        end
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, ".SO"},       32'(bus_a.SO),       32'd0);
        check({tag, ".so_valid"}, 32'(bus_a.so_valid), 32'd0);
        check({tag, ".so_last"},  32'(bus_a.so_last),  32'd0);
        check({tag, ".busy"},     32'(bus_a.busy),     32'd0);
        check({tag, ".ready"},    32'(bus_a.ready),    32'd1);
    endtask

    // Per-cycle comparison against the model, and handshake decisions for the coming edge.
    always @(negedge clk) begin
        exp_ready_a = (mq_a.size() == 0) || (mq_a.size() == 1 && bus_a.shift_en);
        exp_so_a    = (mq_a.size() != 0) && mq_a[0];
        check("a.SO",       32'(bus_a.SO),       32'(exp_so_a));
        check("a.so_valid", 32'(bus_a.so_valid), 32'(mq_a.size() != 0));
        check("a.so_last",  32'(bus_a.so_last),  32'(mq_a.size() == 1));
        check("a.busy",     32'(bus_a.busy),     32'(mq_a.size() != 0));
        check("a.ready",    32'(bus_a.ready),    32'(exp_ready_a));
        acc_a  = reset_n && bus_a.load && exp_ready_a;
        cons_a = reset_n && (mq_a.size() != 0) && bus_a.shift_en;

        exp_ready_b = (mq_b.size() == 0) || (mq_b.size() == 1 && bus_b.shift_en);
        exp_so_b    = (mq_b.size() != 0) && mq_b[0];
        check("b.SO",       32'(bus_b.SO),       32'(exp_so_b));
        check("b.so_valid", 32'(bus_b.so_valid), 32'(mq_b.size() != 0));
        check("b.so_last",  32'(bus_b.so_last),  32'(mq_b.size() == 1));
        check("b.busy",     32'(bus_b.busy),     32'(mq_b.size() != 0));
        check("b.ready",    32'(bus_b.ready),    32'(exp_ready_b));
        acc_b  = reset_n && bus_b.load && exp_ready_b;
        cons_b = reset_n && (mq_b.size() != 0) && bus_b.shift_en;
    end

    // Model update at the edge: consume the head bit, then append an accepted word.
    always @(posedge clk) begin
        if (reset_n) begin
            if (cons_a) void'(mq_a.pop_front());
            if (acc_a) begin
                for (int k = 0; k < 4; k++) mq_a.push_back(bus_a.I[k]);
                if (fq_a.size() != 0) void'(fq_a.pop_front());
            end
            if (cons_b) void'(mq_b.pop_front());
            if (acc_b) begin
                for (int k = 0; k < 8; k++) mq_b.push_back(bus_b.I[7-k]);
                if (fq_b.size() != 0) void'(fq_b.pop_front());
            end
        end
    end

    // Reset discards everything in flight.
    always @(negedge reset_n) begin
        mq_a.delete();
        mq_b.delete();
        acc_a = 1'b0; cons_a = 1'b0; acc_b = 1'b0; cons_b = 1'b0;
    end

    // Upstream re-presents its head word just after each edge.
    always @(posedge clk) begin
        #1;
        refresh();
    end

    initial begin
        bus_a.load = 1'b0; bus_a.I = '0; bus_a.shift_en = 1'b0;
        bus_b.load = 1'b0; bus_b.I = '0; bus_b.shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_idle_now("reset");
        reset_n = 1'b1;

        // Released with load low: stays idle.
        run(0, 2, 16'hFFFF);
        check("post_reset.valid", 32'(rec_valid[1:0]), 32'h0);
        check("post_reset.ready", 32'(rec_ready[1:0]), 32'h3);

        // Single word 1011, LSB first.
        tick(); fq_a.push_back(8'h0B); refresh();
        run(0, 5, 16'hFFFF);
        check("single.so",    32'(rec_so[4:0]),    32'h0B);
        check("single.valid", 32'(rec_valid[4:0]), 32'h0F);
        check("single.busy",  32'(rec_busy[4:0]),  32'h0F);
        check("single.last",  32'(rec_last[4:0]),  32'h08);
        check("single.ready", 32'(rec_ready[4:0]), 32'h18);

        // Same word, 3-cycle stall on the 2nd bit.
        tick(); fq_a.push_back(8'h0B); refresh();
        run(0, 8, 16'h00F1);
        check("stall.so",    32'(rec_so[7:0]),    32'h5F);
        check("stall.valid", 32'(rec_valid[7:0]), 32'h7F);
        check("stall.last",  32'(rec_last[7:0]),  32'h40);
        check("stall.ready", 32'(rec_ready[7:0]), 32'hC0);

        // Back-to-back 1011 then 0110 with load held.
        tick(); fq_a.push_back(8'h0B); fq_a.push_back(8'h06); refresh();
        run(0, 9, 16'hFFFF);
        check("b2b.so",    32'(rec_so[8:0]),    32'h06B);
        check("b2b.valid", 32'(rec_valid[8:0]), 32'h0FF);
        check("b2b.last",  32'(rec_last[8:0]),  32'h088);
        check("b2b.ready", 32'(rec_ready[8:0]), 32'h188);

        // Reset after two bits of 1011, with load asserted during reset.
        tick(); fq_a.push_back(8'h0B); refresh();
        run(0, 2, 16'hFFFF);
        check("midrst.so",    32'(rec_so[1:0]),    32'h3);
        check("midrst.last",  32'(rec_last[1:0]),  32'h0);
        #1;
        reset_n = 1'b0;
        fq_a.delete(); fq_b.delete();
        bus_a.load = 1'b1; bus_a.I = 4'($urandom);
        #1;
        check_idle_now("midrst");
        tick(); bus_a.load = 1'b1;
        tick(); reset_n = 1'b1;
        run(0, 2, 16'hFFFF);
        check("midrst.idle_valid", 32'(rec_valid[1:0]), 32'h0);
        tick(); fq_a.push_back(8'h01); refresh();
        run(0, 5, 16'hFFFF);
        check("midrst.so",    32'(rec_so[4:0]),    32'h01);
        check("midrst.valid", 32'(rec_valid[4:0]), 32'h0F);
        check("midrst.last",  32'(rec_last[4:0]),  32'h08);

        // MSB first, n=8, A5.
        tick(); fq_b.push_back(8'hA5); refresh();
        run(1, 9, 16'hFFFF);
        check("msb.so",    32'(rec_so[8:0]),    32'h0A5);
        check("msb.valid", 32'(rec_valid[8:0]), 32'h0FF);
        check("msb.last",  32'(rec_last[8:0]),  32'h080);
        check("msb.ready", 32'(rec_ready[8:0]), 32'h180);

        // Randomized streaming with stalls on both instances, one reset midway.
        for (int c = 0; c < 800; c++) begin
            tick();
            bus_a.shift_en = ($urandom_range(0, 3) != 0);
            bus_b.shift_en = ($urandom_range(0, 3) != 0);
            if (fq_a.size() < 2 && $urandom_range(0, 2) != 0) fq_a.push_back(8'($urandom));
            if (fq_b.size() < 2 && $urandom_range(0, 2) != 0) fq_b.push_back(8'($urandom));
            refresh();
            if (c == 400) begin
                #4;
                reset_n = 1'b0;
                fq_a.delete(); fq_b.delete();
                tick();
                reset_n = 1'b1;
            end
        end

        // Drain with shift_en held high.
        bus_a.shift_en = 1'b1;
        bus_b.shift_en = 1'b1;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter for the shift-register family. Accepts an n-bit parallel word through a valid/ready handshake and shifts it out one bit per enabled clock, with bit-valid and last-bit markers. It is the transmit end of the serial link: a downstream serial-in deserializer consumes SO/so_valid/so_last and rebuilds the word. Back-to-back words stream with no idle cycle between them.

## Interface
- n, default 4: word width in bits. Legal range is n >= 2.
- LSB_FIRST, default 1: 1 = I[0] is transmitted first; 0 = I[n-1] is transmitted first.

- clk  input  1  clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- I  input  n  parallel word to transmit
- load  input  1  word-valid; I is captured when load && ready at a rising edge
- ready  output  1  block can accept a word this cycle (combinational, see Operation)
- shift_en  input  1  downstream accepts the current bit this cycle (stall when low)
- SO  output  1  current serial bit
- so_valid  output  1  SO holds a valid bit
- so_last  output  1  SO is the final bit of the current word
- busy  output  1  a word is being shifted (identical to so_valid)

## Operation
- State:
  - shift register `sr[n-1:0]`.
  - bit counter `cnt`, width $clog2(n), holding the number of bits remaining after the current one.
  - state, IDLE or SHIFT.
- Reset (reset_n low, asynchronous): state=IDLE, sr=0, cnt=0. Outputs during and after reset: SO=0, so_valid=0, so_last=0, busy=0, ready=1.
  - load is ignored while reset_n is low.
- SO selects sr[0] when LSB_FIRST=1, and sr[n-1] otherwise.
- so_valid = busy = (state==SHIFT).
- so_last = (state==SHIFT && cnt==0).
- ready = (state==IDLE) || (state==SHIFT && cnt==0 && shift_en).
- IDLE:
  - load && ready: sr<=I, cnt<=n-1, go to SHIFT.
  - otherwise: hold.
- SHIFT with shift_en=0: full hold. sr, cnt and all outputs stay unchanged. A load is not accepted because ready=0.
- SHIFT with shift_en=1 and cnt!=0:
  - shift sr toward the output end. For LSB_FIRST=1 this is a right shift; for LSB_FIRST=0 it is a left shift.
  - fill the vacated bit with 0.
  - cnt<=cnt-1.
- SHIFT with shift_en=1 and cnt==0 (last bit consumed):
  - if load: sr<=I, cnt<=n-1, stay in SHIFT (back-to-back).
  - else: go to IDLE. sr is cleared to 0, so SO=0 in IDLE.
- Changes to I after capture have no effect on the word in flight.
- When shift_en=1 on every SHIFT cycle, each word occupies exactly n SHIFT cycles.

## Timing
- Capture latency: a word accepted at edge k presents its first bit on SO, with so_valid=1, in the cycle after edge k. This is 1 cycle of latency.
- A bit is consumed at any edge where so_valid && shift_en.
- so_last is high for exactly the final bit and stays high across stalls.
- Continuous streaming:
  - With load held high and shift_en=1, ready pulses during each so_last cycle.
  - The next word's first bit follows the previous last bit on the next cycle, with no gap and so_valid continuously high.
- Reset mid-word: the in-flight word is discarded immediately (asynchronously). so_valid falls without so_last having been seen. The next word after reset starts fresh.
- Simultaneous events:
  - load with ready=0 is not accepted. The upstream holds load and I until ready.
  - A load in the same cycle as the last-bit shift is accepted: the hand-off case above.
- All outputs except ready are functions of registered state only. ready additionally depends combinationally on shift_en.

## Test plan
- **Reset:** assert reset_n=0 mid-cycle with arbitrary inputs.
  - Required: SO=0, so_valid=0, so_last=0, busy=0, ready=1 immediately, before the next edge.
  - Required: state holds after release with load=0.
- **Single word, n=4, LSB_FIRST=1:** I=4'b1011, load for one cycle, shift_en=1.
  - Required: SO sequence 1,1,0,1 on 4 consecutive cycles with so_valid=1 throughout.
  - Required: so_last only on the 4th bit, ready=1 during that cycle, then so_valid=0 and ready=1.
- **Stall:** same word with shift_en=0 during the 2nd bit for 3 cycles.
  - Required: SO=1 and cnt unchanged for the stall, ready=0.
  - Required: the sequence then completes 1,1,0,1 in 7 cycles total, with so_last only on the final bit.
- **Back-to-back:** load held high with I=4'b1011 then 4'b0110, shift_en=1.
  - Required: SO=1,1,0,1,0,1,1,0 over 8 consecutive cycles, with no so_valid gap.
  - Required: so_last on cycles 4 and 8, and the second word is accepted at the 4th-bit edge.
- **Reset mid-word:** assert reset_n after 2 bits of 4'b1011.
  - Required: so_valid drops immediately with no so_last.
  - Required: after release, load I=4'b0001 yields 1,0,0,0 with so_last on the 4th bit.
- **MSB-first, n=8, LSB_FIRST=0:** I=8'hA5.
  - Required: SO=1,0,1,0,0,1,0,1, with so_last on the 8th bit and ready=0 during bits 1–7.
